// File: rtl/posit_pkg.sv
// Shared posit definitions: default geometry, derived field widths and special encodings.
package posit_pkg;

   localparam int POSIT_N  = 8;
   localparam int POSIT_ES = 4;

   function automatic int log2c(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int mant_w(input int n, input int e);
      return n - e + 3;
   endfunction

   function automatic int sum_w(input int n, input int e);
      return n - e + 5;
   endfunction

   function automatic int exp_w(input int bs, input int e);
      return bs + e + 2;
   endfunction

   localparam int MANT_W = mant_w(POSIT_N, POSIT_ES);
   localparam int SUM_W  = sum_w(POSIT_N, POSIT_ES);
   localparam int EXP_W  = exp_w(log2c(POSIT_N), POSIT_ES);

   // Encodings are returned right-aligned in 64 bits; callers slice to N.
   function automatic logic [63:0] posit_nar(input int n);
      return 64'd1 << (n - 1);
   endfunction

   function automatic logic [63:0] posit_zero(input int n);
      return ((64'd1 << n) - 64'd1) & 64'd0;
   endfunction

   function automatic logic [63:0] posit_maxpos(input int n);
      return (64'd1 << (n - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] posit_minpos(input int n);
      return 64'(n > 1);
   endfunction

endpackage

// File: rtl/posit_lzd.sv
// Combinational leading-zero counter; an all-zero input returns W.
module posit_lzd #(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  din,
   output logic [CW-1:0] cnt
);

   logic found;

   always_comb begin
      cnt   = CW'(W);
      found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!found && din[i]) begin
            cnt   = CW'(W - 1 - i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/posit_normalise_encode.sv
// Posit adder back end: normalise, regime/exp/fraction split, RNE round, pack.
// 3-cycle pipeline, 1/cycle, valid/ready with full backpressure (no skid).
module posit_normalise_encode
   import posit_pkg::*;
#(
   parameter int N  = POSIT_N,
   parameter int Bs = log2c(N),
   parameter int es = POSIT_ES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [N-es+4:0] sum,
   input  logic signed [Bs+es:0]  eeff,
   input  logic                 nar_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         posit_out
);

   localparam bit DEF = (N == POSIT_N) && (es == POSIT_ES) && (Bs == log2c(POSIT_N));
   localparam int SW  = DEF ? SUM_W  : sum_w(N, es);
   localparam int FW  = DEF ? MANT_W : mant_w(N, es);
   localparam int XW  = DEF ? EXP_W  : exp_w(Bs, es);
   localparam int MW  = SW - 1;
   localparam int KW  = XW - es;
   localparam int LW  = log2c(MW + 1);
   localparam int BW  = 2 + es + FW + N;

   localparam logic [N-1:0] NAR    = N'(posit_nar(N));
   localparam logic [N-1:0] ZERO   = N'(posit_zero(N));
   localparam logic [N-1:0] MAXPOS = N'(posit_maxpos(N));
   localparam logic [N-1:0] MINPOS = N'(posit_minpos(N));
   localparam logic signed [KW-1:0] K_MAX = KW'(N - 2);
   localparam logic signed [KW-1:0] K_MIN = KW'(1 - N);

   logic v1, v2, v3;
   logic ld2, ld3;

   assign ld3       = ~v3 | out_ready;
   assign ld2       = ~v2 | ld3;
   assign in_ready  = ~v1 | ld2;
   assign out_valid = v3;

   // ---------------- stage 1: sign/magnitude and leading-zero count
   logic [SW-1:0] sum_abs;
   logic [MW-1:0] mag_c;
   logic [LW-1:0] lz_c;

   assign sum_abs = sum[SW-1] ? -sum : sum;
   // |sum| only overflows MW bits for the most negative code, which the front end never produces.
   assign mag_c   = sum_abs[MW-1:0] | {MW{sum_abs[SW-1]}};

   posit_lzd #(.W(MW), .CW(LW)) u_lzd (
      .din (mag_c),
      .cnt (lz_c)
   );

   logic                  s1_sgn, s1_zero, s1_nar;
   logic [MW-1:0]         s1_mag;
   logic [LW-1:0]         s1_lz;
   logic signed [Bs+es:0] s1_eeff;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1      <= 1'b0;
         s1_sgn  <= 1'b0;
         s1_zero <= 1'b0;
         s1_nar  <= 1'b0;
         s1_mag  <= '0;
         s1_lz   <= '0;
         s1_eeff <= '0;
      end else if (in_ready) begin
         v1 <= in_valid;
         if (in_valid) begin
            s1_sgn  <= sum[SW-1];
            s1_zero <= (mag_c == '0);
            s1_nar  <= nar_in;
            s1_mag  <= mag_c;
            s1_lz   <= lz_c;
            s1_eeff <= eeff;
         end
      end
   end

   // ---------------- stage 2: left-align and split the scale into regime/exponent
   logic [FW-1:0] frac_c;
   logic [XW-1:0] exp_c;

   assign frac_c = FW'(s1_mag << s1_lz);
   assign exp_c  = XW'(s1_eeff) + XW'(1) - XW'(s1_lz);

   logic                 s2_sgn, s2_zero, s2_nar;
   logic signed [KW-1:0] s2_k;
   logic [es-1:0]        s2_e;
   logic [FW-1:0]        s2_frac;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v2      <= 1'b0;
         s2_sgn  <= 1'b0;
         s2_zero <= 1'b0;
         s2_nar  <= 1'b0;
         s2_k    <= '0;
         s2_e    <= '0;
         s2_frac <= '0;
      end else if (ld2) begin
         v2 <= v1;
         if (v1) begin
            s2_sgn  <= s1_sgn;
            s2_zero <= s1_zero;
            s2_nar  <= s1_nar;
            s2_k    <= exp_c[XW-1:es];   // same bits as E >>> es
            s2_e    <= exp_c[es-1:0];
            s2_frac <= frac_c;
         end
      end
   end

   // ---------------- stage 3: regime build, round, saturate, sign
   logic                 sat_hi, sat_lo, run, guard, sticky, rnd;
   logic [KW-1:0]        shamt;
   logic signed [BW-1:0] body0, body_sh;
   logic [N-2:0]         top;
   logic [N-1:0]         rounded, mag_p, pack_c;

   assign sat_hi = (s2_k >= K_MAX);
   assign sat_lo = (s2_k <= K_MIN);
   assign run    = ~s2_k[KW-1];
   assign shamt  = s2_k[KW-1] ? ~s2_k : s2_k;

   // Run bit at the MSB, terminator next; the arithmetic shift stretches the run to its length.
   assign body0   = {run, ~run, s2_e, s2_frac, {N{1'b0}}};
   assign body_sh = body0 >>> shamt;
   assign top     = body_sh[BW-1 -: N-1];
   assign guard   = body_sh[BW-N];
   assign sticky  = |body_sh[BW-N-1:0];
   assign rnd     = guard & (top[0] | sticky);
   assign rounded = {1'b0, top} + {{(N-1){1'b0}}, rnd};

   always_comb begin
      mag_p = rounded;
      if (sat_hi || rounded[N-1]) mag_p = MAXPOS;
      else if (sat_lo)            mag_p = MINPOS;

      pack_c = s2_sgn ? -mag_p : mag_p;
      if (s2_nar)       pack_c = NAR;
      else if (s2_zero) pack_c = ZERO;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v3        <= 1'b0;
         posit_out <= '0;
      end else if (ld3) begin
         v3 <= v2;
         if (v2) posit_out <= pack_c;
      end
   end

endmodule

// File: tb/tb_posit_normalise_encode.sv
// Directed-vector bench for posit_normalise_encode (N=8, es=4): latency, rounding, specials, backpressure, reset.
module tb_posit_normalise_encode;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic signed [8:0] sum;
   logic signed [7:0] eeff;
   logic              nar_in;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        posit_out;

   int n_vec = 0;
   int n_bad = 0;

   posit_normalise_encode #(.N(8), .Bs(3), .es(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum       (sum),
      .eeff      (eeff),
      .nar_in    (nar_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .posit_out (posit_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Single transaction on an idle pipe: result must appear exactly after the third edge.
   task automatic run_vec(input string tag, input logic signed [8:0] s, input logic signed [7:0] e,
                          input logic n, input logic [7:0] x);
      sum      = s;
      eeff     = e;
      nar_in   = n;
      in_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_early1"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_early2"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_posit"}, 32'(posit_out), 32'(x));
      @(posedge clk); #1;
   endtask

   logic signed [8:0] bp_s[5] = '{9'sd64, 9'sd128, -9'sd64, 9'sd96, 9'sd64};
   logic signed [7:0] bp_e[5] = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd127};
   logic [7:0]        bp_x[5] = '{8'h40, 8'h42, 8'hC0, 8'h41, 8'h7F};

   initial begin
      int         acc, nout;
      logic       held_prev;
      logic [7:0] prev_out;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sum       = '0;
      eeff      = '0;
      nar_in    = 1'b0;
      #12;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_posit_out", 32'(posit_out), 32'd0);
      reset = 1'b0;
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      run_vec("one",       9'sd64,   8'sd0,    1'b0, 8'h40);
      run_vec("carry",     9'sd128,  8'sd0,    1'b0, 8'h42);
      run_vec("neg_one",  -9'sd64,   8'sd0,    1'b0, 8'hC0);
      run_vec("g0",        9'sd80,   8'sd0,    1'b0, 8'h40);
      run_vec("tie_up",    9'sd112,  8'sd0,    1'b0, 8'h42);
      run_vec("frac_1p5",  9'sd96,   8'sd0,    1'b0, 8'h41);
      run_vec("maxpos",    9'sd64,   8'sd127,  1'b0, 8'h7F);
      run_vec("minpos",    9'sd64,  -8'sd128,  1'b0, 8'h01);
      run_vec("zero",      9'sd0,    8'sd0,    1'b0, 8'h00);
      run_vec("nar",       9'sd64,   8'sd0,    1'b1, 8'h80);
      run_vec("half",      9'sd32,   8'sd0,    1'b0, 8'h3E);
      run_vec("neg_1p75", -9'sd112,  8'sd0,    1'b0, 8'hBE);
      run_vec("k1",        9'sd64,   8'sd16,   1'b0, 8'h60);
      run_vec("k5_round",  9'sd127,  8'sd95,   1'b0, 8'h7F);
      run_vec("km6",       9'sd64,  -8'sd96,   1'b0, 8'h01);
      run_vec("km6_round", 9'sd64,  -8'sd81,   1'b0, 8'h02);

      // Backpressure: sink stalled for 6 cycles while 5 inputs are offered.
      acc       = 0;
      nout      = 0;
      held_prev = 1'b0;
      prev_out  = '0;
      for (int c = 0; c < 40; c++) begin
         out_ready = (c >= 6);
         in_valid  = (acc < 5);
         if (acc < 5) begin
            sum    = bp_s[acc];
            eeff   = bp_e[acc];
            nar_in = 1'b0;
         end
         @(negedge clk);
         if (c == 5) begin
            chk("bp_accepts", 32'(acc), 32'd3);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
         end
         if (held_prev) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_posit", 32'(posit_out), 32'(prev_out));
         end
         if (out_valid && out_ready) begin
            if (nout < 5) chk($sformatf("bp_out%0d", nout), 32'(posit_out), 32'(bp_x[nout]));
            nout++;
         end
         held_prev = out_valid & ~out_ready;
         prev_out  = posit_out;
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("bp_out_count", 32'(nout), 32'd5);

      // Reset with a full pipe: output drops at once and nothing stale follows.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sum      = 9'sd64;
         eeff     = 8'sd0;
         nar_in   = 1'b0;
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_pre_valid", 32'(out_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_posit_out", 32'(posit_out), 32'd0);
      @(negedge clk);
      reset     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("rst_stale%0d", i), 32'(out_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
